// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//
// Single-clock first-in-first-out buffer of DATA_WIDTH-bit words, DEPTH
// entries deep, used to decouple a producer and a consumer that share a clock.
//
// Ports
//   clock     in   1           rising-edge clock for all state
//   resetn    in   1           asynchronous reset, ACTIVE-HIGH despite the name
//   wr_en     in   1           write request; data_in captured when accepted
//   rd_en     in   1           read request; head word moved to data_out
//   data_in   in   DATA_WIDTH  write data
//   full      out  1           occupancy == DEPTH
//   empty     out  1           occupancy == 0
//   data_out  out  DATA_WIDTH  registered read data, holds between reads
//
// Writes while full (without a same-cycle read) and reads while empty are
// dropped and leave all state untouched. Read latency is one cycle and there
// is no fall-through: a word written on edge N is readable from edge N+1.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [AW:0]           count;

  logic                  rd_accept;
  logic                  wr_accept;

  // Status comes from the count register alone, so it never depends on the
  // same-cycle requests and cannot form a combinational loop with the source.
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A read frees the head slot on the same edge, so a full FIFO can still
  // accept a write when it is also being read.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);

  // NOTE: the storage array is deliberately left out of reset; clearing it
  // would only add reset fan-out, and no entry is read before it is written.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[wptr] <= data_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_accept) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_accept) begin
        rptr     <= rptr + 1'b1;
        data_out <= mem[rptr];
      end
      unique case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
//
// Directed bench for sync_fifo at DEPTH=256. A queue holds the words expected
// to come out, and each step says by hand whether a write is expected to be
// kept or dropped. Inputs change and outputs are sampled 1 time unit after
// each rising edge.
// ---------------------------------------------------------------------------
module tb_sync_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 256;

  logic          clock = 1'b0;
  logic          resetn;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] data_in;
  logic          full;
  logic          empty;
  logic [DW-1:0] data_out;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q [$];
  logic [DW-1:0] last;

  sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .full     (full),
    .empty    (empty),
    .data_out (data_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tagged, always non-zero test word.
  function automatic logic [DW-1:0] word(input int tag, input int i);
    return {tag[7:0], 8'h5a, i[15:0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Write-only cycle; 'keep' says whether the FIFO is expected to store it.
  task automatic push(input logic [DW-1:0] w, input bit keep);
    wr_en   = 1'b1;
    rd_en   = 1'b0;
    data_in = w;
    tick();
    if (keep) q.push_back(w);
  endtask

  // Read-only cycle that must return the oldest expected word.
  task automatic pop_check(input string tag);
    logic [DW-1:0] exp;
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    exp  = q.pop_front();
    check(tag, data_out, exp);
    last = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn  = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    repeat (3) tick();
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_dout", data_out, '0);
    resetn = 1'b0;
    tick();

    // Basic order: 24 back-to-back writes, then 20 + 4 back-to-back reads.
    for (int i = 0; i < 24; i++) push(word(1, i), 1'b1);
    check("basic_not_empty", empty, 1'b0);
    for (int i = 0; i < 20; i++) pop_check("basic_pop20");
    for (int i = 0; i < 4; i++) pop_check("basic_pop4");
    check("basic_empty", empty, 1'b1);
    check("basic_full", full, 1'b0);

    // Read while empty: data_out holds the last popped word.
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("uflow_dout", data_out, last);
      check("uflow_empty", empty, 1'b1);
      check("uflow_full", full, 1'b0);
    end
    rd_en = 1'b0;

    // Fill to 100 and drain; full must never assert.
    for (int i = 0; i < 100; i++) begin
      push(word(2, i), 1'b1);
      check("fill100_full", full, 1'b0);
    end
    for (int i = 0; i < 100; i++) pop_check("drain100");
    check("drain100_empty", empty, 1'b1);

    // Reset in the middle of traffic; outputs clear without a clock edge.
    for (int i = 0; i < 10; i++) push(word(3, i), 1'b1);
    wr_en = 1'b0;
    #2;
    resetn = 1'b1;
    #1;
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_full", full, 1'b0);
    check("mid_rst_dout", data_out, '0);
    q.delete();
    repeat (5) tick();
    check("mid_rst_hold_empty", empty, 1'b1);
    check("mid_rst_hold_dout", data_out, '0);
    resetn = 1'b0;
    push(word(4, 0), 1'b1);
    pop_check("post_rst_first");
    check("post_rst_empty", empty, 1'b1);

    // Overflow: 261 writes, only the first 256 are kept; pointers wrap.
    for (int i = 0; i < DEPTH + 5; i++) begin
      push(word(5, i), i < DEPTH);
      if (i == DEPTH - 2) check("ovf_not_full_255", full, 1'b0);
      if (i == DEPTH - 1) check("ovf_full_256", full, 1'b1);
    end
    check("ovf_full_end", full, 1'b1);
    for (int i = 0; i < DEPTH; i++) pop_check("ovf_pop");
    check("ovf_last_word", last, word(5, DEPTH - 1));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ovf_extra_dout", data_out, last);
      check("ovf_extra_empty", empty, 1'b1);
    end
    rd_en = 1'b0;

    // Simultaneous read and write while full.
    for (int i = 0; i < DEPTH; i++) push(word(6, i), 1'b1);
    check("sim_full_pre", full, 1'b1);
    for (int k = 0; k < 3; k++) begin
      logic [DW-1:0] exp;
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      data_in = word(7, k);
      tick();
      exp = q.pop_front();
      q.push_back(word(7, k));
      check("sim_full_dout", data_out, exp);
      check("sim_full_flag", full, 1'b1);
      last = exp;
    end
    for (int i = 0; i < DEPTH; i++) pop_check("sim_full_drain");
    check("sim_full_drain_empty", empty, 1'b1);
    rd_en = 1'b0;

    // Simultaneous read and write while empty: only the write is taken.
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    data_in = word(8, 0);
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    q.push_back(word(8, 0));
    check("sim_empty_dout", data_out, last);
    check("sim_empty_empty", empty, 1'b0);
    check("sim_empty_full", full, 1'b0);
    pop_check("sim_empty_pop");
    check("sim_empty_end", empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
